dsm_sync: RTL and testbench

DSM_SYNC -- requirements
Module: dsm_sync

---
 rtl/dsm_pkg.sv | 25 ++
 rtl/dsm_xpt_mux.sv | 37 +++
 rtl/dsm_sync.sv | 118 +++++++++++
 tb/tb_dsm_sync.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsm_pkg.sv
// Shared types and defaults for the dsm_sync crosspoint switch.
// An entry selects one input port for one output port and enables it.
package dsm_pkg;

   localparam int N_IN_DEF  = 16;
   localparam int N_OUT_DEF = 16;
   localparam int DW_DEF    = 1;
   // Upper bound on the select width, so one entry type serves every N_IN up to 256.
   localparam int SEL_MAX_W = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   typedef struct packed {
      logic                 en;
      logic [SEL_MAX_W-1:0] sel;
   } entry_t;

   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dsm_xpt_mux.sv
// One output of the crosspoint: registered N_IN:1 mux of DW-bit ports,
// forced to zero when the routing entry is disabled.
module dsm_xpt_mux
   import dsm_pkg::*;
#(
   parameter int N_IN = N_IN_DEF,
   parameter int DW   = DW_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  entry_t             entry,
   input  logic [N_IN*DW-1:0] di,
   output logic [DW-1:0]      dout
);

   logic [DW-1:0] dout_d;
   logic [DW-1:0] dout_q;

   // NOTE: default assigned first so every path through the block drives dout_d; no latch.
   always_comb begin
      dout_d = '0;
      if (entry.en) begin
         for (int i = 0; i < N_IN; i++) begin
            if (entry.sel == SEL_MAX_W'(i)) dout_d = di[i*DW +: DW];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dout_q <= '0;
      else        dout_q <= dout_d;
   end

   assign dout = dout_q;

endmodule

// File: rtl/dsm_sync.sv
// Frame-synchronous crosspoint switch: a shadow routing table is written entry by
// entry and copied whole into the active table on a FRAME strobe after LOAD.
module dsm_sync
   import dsm_pkg::*;
#(
   parameter int  N_IN  = N_IN_DEF,
   parameter int  N_OUT = N_OUT_DEF,
   parameter int  DW    = DW_DEF,
   localparam int SELW  = addr_w(N_IN),
   localparam int OAW   = addr_w(N_OUT)
) (
   input  logic                CLK,
   input  logic                RES_N,
   input  logic                CS,
   input  logic                CNFG,
   input  logic                LOAD,
   input  logic                RES,
   input  logic                FRAME,
   input  logic [SELW-1:0]     In_add,
   input  logic [OAW-1:0]      out_add,
   input  logic                EN,
   input  logic [N_IN*DW-1:0]  di,
   output logic [N_OUT*DW-1:0] dout,
   output logic                BUSY,
   output logic                PEND,
   output logic                ERR
);

   state_t         state_q, state_d;
   logic [OAW-1:0] idx_q, idx_d;
   logic           pend_q, pend_d;
   logic           err_q, err_d;
   entry_t         shadow_q [N_OUT];
   entry_t         shadow_d [N_OUT];
   entry_t         active_q [N_OUT];
   entry_t         active_d [N_OUT];

   logic busy, res_cmd, wr_req, range_ok, xfer;

   always_comb begin
      busy     = (state_q == CLEAR);
      res_cmd  = CS & RES;
      wr_req   = CS & CNFG & ~res_cmd;
      range_ok = (int'(out_add) < N_OUT) && (int'(In_add) < N_IN);
      xfer     = (pend_q | (CS & LOAD)) & FRAME & ~busy;

      state_d  = state_q;
      idx_d    = idx_q;
      pend_d   = pend_q;
      err_d    = err_q;
      shadow_d = shadow_q;
      active_d = active_q;

      // The transfer copies shadow_q, so a write on the same edge lands in shadow only.
      if (xfer) begin
         active_d = shadow_q;
         pend_d   = 1'b0;
      end else if (CS & LOAD) begin
         pend_d   = 1'b1;
      end

      if (res_cmd) begin
         state_d = CLEAR;
         idx_d   = '0;
         err_d   = 1'b0;
      end else if (busy) begin
         shadow_d[idx_q] = '0;
         if (int'(idx_q) == N_OUT - 1) state_d = IDLE;
         else                          idx_d   = idx_q + 1'b1;
      end

      if (wr_req) begin
         if (busy || !range_ok) begin
            err_d = 1'b1;
         end else begin
            shadow_d[out_add].en  = EN;
            shadow_d[out_add].sel = SEL_MAX_W'(In_add);
         end
      end
   end

   // NOTE: both tables are reset because they must read as zero while RES_N is low.
   always_ff @(posedge CLK or negedge RES_N) begin
      if (!RES_N) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         pend_q   <= 1'b0;
         err_q    <= 1'b0;
         shadow_q <= '{default: '0};
         active_q <= '{default: '0};
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         pend_q   <= pend_d;
         err_q    <= err_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end

   for (genvar o = 0; o < N_OUT; o++) begin : g_out
      dsm_xpt_mux #(
         .N_IN (N_IN),
         .DW   (DW)
      ) u_mux (
         .clk   (CLK),
         .rst_n (RES_N),
         .entry (active_q[o]),
         .di    (di),
         .dout  (dout[o*DW +: DW])
      );
   end

   assign BUSY = busy;
   assign PEND = pend_q;
   assign ERR  = err_q;

endmodule

// File: tb/tb_dsm_sync.sv
// Self-checking bench for dsm_sync: vector table for routing plus hand-written
// sequences for load timing, soft clear, same-edge write/transfer and async reset.
module tb_dsm_sync;

   localparam int N_IN  = 12;
   localparam int N_OUT = 16;
   localparam int DW    = 2;
   localparam int SELW  = 4;
   localparam int OAW   = 4;

   logic                CLK = 1'b0;
   logic                RES_N = 1'b0;
   logic                CS, CNFG, LOAD, RES, FRAME, EN;
   logic [SELW-1:0]     In_add;
   logic [OAW-1:0]      out_add;
   logic [N_IN*DW-1:0]  di;
   logic [N_OUT*DW-1:0] dout;
   logic                BUSY, PEND, ERR;

   dsm_sync #(
      .N_IN  (N_IN),
      .N_OUT (N_OUT),
      .DW    (DW)
   ) dut (
      .CLK     (CLK),
      .RES_N   (RES_N),
      .CS      (CS),
      .CNFG    (CNFG),
      .LOAD    (LOAD),
      .RES     (RES),
      .FRAME   (FRAME),
      .In_add  (In_add),
      .out_add (out_add),
      .EN      (EN),
      .di      (di),
      .dout    (dout),
      .BUSY    (BUSY),
      .PEND    (PEND),
      .ERR     (ERR)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [N_IN*DW-1:0]  di;
      logic [N_OUT*DW-1:0] exp_do;
   } vec_t;

   vec_t        vecs [8];
   int          n_chk  = 0;
   int          n_pass = 0;
   logic [31:0] sb_q [$];

   // Reference routing tables, updated where a write or transfer is expected.
   bit m_sh_en  [N_OUT];
   int m_sh_sel [N_OUT];
   bit m_act_en [N_OUT];
   int m_act_sel[N_OUT];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [N_IN*DW-1:0] port(input int i, input logic [DW-1:0] v);
      logic [N_IN*DW-1:0] r;
      r = '0;
      r[i*DW +: DW] = v;
      return r;
   endfunction

   function automatic logic [N_OUT*DW-1:0] model_do(input logic [N_IN*DW-1:0] d);
      logic [N_OUT*DW-1:0] r;
      r = '0;
      for (int o = 0; o < N_OUT; o++)
         if (m_act_en[o]) r[o*DW +: DW] = d[m_act_sel[o]*DW +: DW];
      return r;
   endfunction

   task automatic idle_in();
      CS = 0; CNFG = 0; LOAD = 0; RES = 0; FRAME = 0; EN = 0;
      In_add = '0; out_add = '0;
   endtask

   task automatic wr(input int o, input int i, input bit en);
      CS = 1; CNFG = 1; out_add = OAW'(o); In_add = SELW'(i); EN = en;
   endtask

   task automatic zero_shadow_model();
      for (int o = 0; o < N_OUT; o++) begin
         m_sh_en[o] = 0; m_sh_sel[o] = 0;
      end
   endtask

   task automatic take_transfer();
      m_act_en  = m_sh_en;
      m_act_sel = m_sh_sel;
   endtask

   // One clock: expected do is queued with the stimulus and retired after the edge.
   task automatic cyc(input string tag);
      logic [31:0] e;
      sb_q.push_back(model_do(di));
      @(posedge CLK);
      #1;
      e = sb_q.pop_front();
      check(tag, dout, e);
   endtask

   task automatic count_busy(input string tag, inout int busy_n);
      int guard;
      guard = 0;
      while (BUSY === 1'b1 && guard < 40) begin
         cyc(tag);
         if (BUSY === 1'b1) busy_n++;
         guard++;
      end
      if (guard >= 40) check({tag, "_timeout"}, 32'(guard), 32'd0);
   endtask

   initial begin
      int busy_n;

      // Routes used by the table: out0<-in0, out1<-in11, out3<-in7, out5<-in2 disabled.
      vecs[0] = '{24'h000000, 32'h0000_0000};
      vecs[1] = '{24'hFFFFFF, 32'h0000_00CF};
      vecs[2] = '{24'h004000, 32'h0000_0040};
      vecs[3] = '{24'h000002, 32'h0000_0002};
      vecs[4] = '{24'h400000, 32'h0000_0004};
      vecs[5] = '{24'h000030, 32'h0000_0000};
      vecs[6] = '{24'hC08000, 32'h0000_008C};
      vecs[7] = '{24'h0000CC, 32'h0000_0000};

      idle_in();
      di = 24'hFFFFFF;
      zero_shadow_model();
      take_transfer();

      // Reset held across several edges.
      #12;
      check("rst_do", dout, 32'h0);
      check("rst_busy", BUSY, 0);
      check("rst_pend", PEND, 0);
      check("rst_err", ERR, 0);
      @(posedge CLK);
      #1;
      RES_N = 1;

      // Write right after release, LOAD, FRAME five cycles later.
      di = port(7, 1);
      wr(3, 7, 1);
      cyc("s1_wr");
      m_sh_en[3] = 1; m_sh_sel[3] = 7;
      check("s1_err", ERR, 0);
      idle_in(); CS = 1; LOAD = 1;
      cyc("s1_load");
      check("s1_pend_0", PEND, 1);
      idle_in();
      for (int k = 1; k < 5; k++) begin
         cyc("s1_wait");
         check($sformatf("s1_pend_%0d", k), PEND, 1);
      end
      FRAME = 1;
      cyc("s1_xfer");
      take_transfer();
      check("s1_pend_clr", PEND, 0);
      FRAME = 0;
      cyc("s1_after");
      check("s1_do3", dout, 32'h40);

      // More routes, then LOAD and FRAME together: PEND never seen high.
      wr(0, 0, 1);  cyc("s2_wr0"); m_sh_en[0] = 1; m_sh_sel[0] = 0;
      wr(1, 11, 1); cyc("s2_wr1"); m_sh_en[1] = 1; m_sh_sel[1] = 11;
      wr(5, 2, 0);  cyc("s2_wr5"); m_sh_en[5] = 0; m_sh_sel[5] = 2;
      idle_in(); CS = 1; LOAD = 1; FRAME = 1;
      cyc("s2_xfer");
      take_transfer();
      check("s2_pend_never", PEND, 0);
      idle_in();
      for (int v = 0; v < 8; v++) begin
         logic [31:0] e;
         di = vecs[v].di;
         sb_q.push_back(vecs[v].exp_do);
         @(posedge CLK);
         #1;
         e = sb_q.pop_front();
         check($sformatf("vec_%0d", v), dout, e);
      end

      // Out-of-range source: dropped, ERR sticky.
      di = port(7, 2);
      wr(3, 13, 1);
      cyc("s3_wr");
      check("s3_err", ERR, 1);
      idle_in(); CS = 1; LOAD = 1; FRAME = 1;
      cyc("s3_xfer");
      take_transfer();
      idle_in();
      cyc("s3_keep");
      check("s3_do3_kept", dout, 32'h80);
      check("s3_err_sticky", ERR, 1);

      // Soft clear with a same-cycle CNFG, write while busy, LOAD deferred.
      di = port(7, 2) | port(0, 1);
      idle_in(); CS = 1; RES = 1; wr(9, 1, 1);
      cyc("s4_start");
      zero_shadow_model();
      check("s4_err_cleared", ERR, 0);
      check("s4_busy_rise", BUSY, 1);
      idle_in(); wr(2, 4, 1); LOAD = 1; FRAME = 1;
      cyc("s4_cnfg");
      check("s4_err_busy_wr", ERR, 1);
      check("s4_pend", PEND, 1);
      idle_in(); FRAME = 1;
      busy_n = 2;
      count_busy("s4_busy", busy_n);
      check("s4_busy_len", 32'(busy_n), 32'd16);
      check("s4_do_hold", dout, 32'h81);
      check("s4_pend_deferred", PEND, 1);
      cyc("s4_xfer");
      take_transfer();
      check("s4_pend_clr", PEND, 0);
      cyc("s4_after");
      check("s4_do_zero", dout, 32'h0);

      // Repeated LOAD, then write and transfer on the same edge.
      idle_in();
      di = port(5, 3) | port(7, 1);
      wr(3, 7, 1);
      cyc("s5_wr3");
      m_sh_en[3] = 1; m_sh_sel[3] = 7;
      idle_in(); CS = 1; LOAD = 1;
      cyc("s5_load1");
      check("s5_pend1", PEND, 1);
      cyc("s5_load2");
      check("s5_pend2", PEND, 1);
      idle_in(); wr(4, 5, 1); FRAME = 1;
      cyc("s5_same");
      take_transfer();
      m_sh_en[4] = 1; m_sh_sel[4] = 5;
      check("s5_pend_clr", PEND, 0);
      idle_in();
      cyc("s5_old");
      check("s5_do_old", dout, 32'h40);
      check("s5_pend_stays", PEND, 0);
      CS = 1; LOAD = 1; FRAME = 1;
      cyc("s5_xfer2");
      take_transfer();
      idle_in();
      cyc("s5_new");
      check("s5_do_new", dout, 32'h340);

      // CS&RES during CLEAR restarts the walk.
      CS = 1; RES = 1;
      cyc("s6_start");
      zero_shadow_model();
      idle_in();
      repeat (5) cyc("s6_mid");
      CS = 1; RES = 1;
      cyc("s6_restart");
      idle_in();
      busy_n = 1;
      count_busy("s6_busy", busy_n);
      check("s6_busy_len", 32'(busy_n), 32'd16);
      check("s6_do_hold", dout, 32'h340);

      // Async reset mid-CLEAR with PEND and ERR set.
      CS = 1; RES = 1; LOAD = 1;
      cyc("s7_clr");
      idle_in(); wr(1, 1, 1);
      cyc("s7_busy_wr");
      idle_in();
      cyc("s7_pre");
      check("s7_pre_flags", {29'd0, BUSY, PEND, ERR}, 32'h7);
      #2;
      RES_N = 0;
      #1;
      check("s7_rst_do", dout, 32'h0);
      check("s7_rst_flags", {29'd0, BUSY, PEND, ERR}, 32'h0);
      zero_shadow_model();
      take_transfer();
      @(negedge CLK);
      RES_N = 1;
      @(posedge CLK);
      #1;
      check("s7_rel_flags", {29'd0, BUSY, PEND, ERR}, 32'h0);
      check("s7_rel_do", dout, 32'h0);
      wr(3, 7, 1);
      cyc("s7_wr");
      m_sh_en[3] = 1; m_sh_sel[3] = 7;
      idle_in(); CS = 1; LOAD = 1; FRAME = 1;
      cyc("s7_xfer");
      take_transfer();
      idle_in();
      cyc("s7_after");
      check("s7_do3", dout, 32'h40);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
